// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer: the buffered
// entry layout plus the strobe/lane encoding used on both the enqueue and
// the load-forwarding side.
package dmem_store_buffer_pkg;

   // One buffered store: word address, lane-aligned data and byte strobes.
   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } sbEntry_t;

   // Word accesses touch every lane; byte accesses touch only the lane
   // picked by the low address bits.
   function automatic logic [3:0] laneStrb(input logic byteAccess,
                                           input logic [1:0] lane);
      logic [3:0] strb;
      if (byteAccess) begin
         strb = 4'b0001 << lane;
      end else begin
         strb = 4'b1111;
      end
      return strb;
   endfunction

   // Build a buffer entry from the core store request. Byte data is
   // replicated to all lanes so the strobe alone decides which lane lands.
   // Word stores drop the low address bits, so misaligned word stores
   // simply hit the containing word.
   function automatic sbEntry_t encodeStore(input logic byteAccess,
                                            input logic [31:0] byteAddr,
                                            input logic [31:0] wdata);
      sbEntry_t e;
      e.addr = byteAddr[31:2];
      e.strb = laneStrb(byteAccess, byteAddr[1:0]);
      if (byteAccess) begin
         e.data = {4{wdata[7:0]}};
      end else begin
         e.data = wdata;
      end
      return e;
   endfunction

   // Pick one byte out of a word by lane number.
   function automatic logic [7:0] selectByte(input logic [31:0] word,
                                             input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Backing-RAM side of the store buffer: a combinational word read port and
// a valid/ready write request port carrying one buffered entry at a time.
interface dmem_store_buffer_if;

   logic [29:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_wvalid;
   logic [29:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_wready;

   // The store buffer drives addresses and write requests.
   modport master (
      output mem_raddr,
      input  mem_rdata,
      output mem_wvalid,
      output mem_waddr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_wready
   );

   // The backing RAM answers reads and accepts writes.
   modport slave (
      input  mem_raddr,
      output mem_rdata,
      input  mem_wvalid,
      input  mem_waddr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_wready
   );

endinterface

// File: rtl/dmem_store_buffer_sb_forward.sv
// Load forwarding merge: overlays every live buffered store that hits the
// load's word onto the RAM read data, oldest first, so the youngest
// matching store wins each byte lane.
module sb_forward
   import dmem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  sbEntry_t         entries_i [DEPTH],
   input  logic [PTR_W-1:0] rdPtr_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [29:0]      addr_i,
   input  logic [31:0]      rdata_i,
   output logic [31:0]      merged_o
);

   logic [PTR_W-1:0] idx;

   // Walk live entries from oldest to youngest; later hits overwrite
   // earlier ones lane by lane, leaving the youngest store's bytes on top.
   always_comb begin
      merged_o = rdata_i;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rdPtr_i + PTR_W'(i);
         if ((CNT_W'(i) < count_i) && (entries_i[idx].addr == addr_i)) begin
            for (int b = 0; b < 4; b++) begin
               if (entries_i[idx].strb[b]) begin
                  merged_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core data-memory port and the backing RAM.
// Stores are queued in order and drained one per accepted write; loads
// see buffered data through a zero-latency forwarding merge.
module dmem_store_buffer
   import dmem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        BEDmem,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        StallM,
   dmem_store_buffer_if.master mem
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   sbEntry_t         entries_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic     empty;
   logic     full;
   logic     push;
   logic     pop;
   sbEntry_t newEntry;
   logic [31:0] mergedWord;

   // Occupancy and handshake decisions. A full buffer can still take a
   // store in the same cycle the RAM accepts the oldest entry.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CNT_W'(DEPTH));
      pop      = !empty && mem.mem_wready;
      push     = MemWrite && (!full || pop);
      StallM   = MemWrite && full && !mem.mem_wready;
      newEntry = encodeStore(BEDmem, ALUResult, WriteData);
   end

   // Next pointer and count values; pointers wrap naturally because DEPTH
   // is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue bookkeeping; clearing the count is enough to discard every
   // buffered store and drop the write request immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry payload storage; validity lives entirely in the count, so the
   // payload itself carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         entries_q[wrPtr_q] <= newEntry;
      end
   end

   // Backing-RAM ports: the oldest entry is always on the write bus, and
   // the read address simply tracks the core address.
   always_comb begin
      mem.mem_wvalid = !empty;
      mem.mem_waddr  = entries_q[rdPtr_q].addr;
      mem.mem_wdata  = entries_q[rdPtr_q].data;
      mem.mem_wstrb  = entries_q[rdPtr_q].strb;
      mem.mem_raddr  = ALUResult[31:2];
   end

   sb_forward #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_forward (
      .entries_i (entries_q),
      .rdPtr_i   (rdPtr_q),
      .count_i   (count_q),
      .addr_i    (ALUResult[31:2]),
      .rdata_i   (mem.mem_rdata),
      .merged_o  (mergedWord)
   );

   // Load data back to the core: full merged word, or one zero-extended
   // byte chosen by the low address bits.
   always_comb begin
      if (BEDmem) begin
         ReadData = {24'b0, selectByte(mergedWord, ALUResult[1:0])};
      end else begin
         ReadData = mergedWord;
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for the store buffer with a small byte-strobed RAM model
// on the backing side and an architectural reference memory for the mixed
// store/load sequence.
module tb_dmem_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        MemWrite;
   logic        BEDmem;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        StallM;

   logic [31:0] ram [256];
   logic [31:0] refMem [4];

   int nChecks;
   int nFails;

   dmem_store_buffer_if memIf ();

   dmem_store_buffer #(
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .MemWrite  (MemWrite),
      .BEDmem    (BEDmem),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .StallM    (StallM),
      .mem       (memIf.master)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational RAM read port.
   assign memIf.mem_rdata = ram[memIf.mem_raddr[7:0]];

   // RAM write port honouring byte strobes.
   always @(posedge clk) begin
      if (memIf.mem_wvalid && memIf.mem_wready) begin
         for (int b = 0; b < 4; b++) begin
            if (memIf.mem_wstrb[b]) begin
               ram[memIf.mem_waddr[7:0]][8*b +: 8] <= memIf.mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of core and RAM inputs, then let them settle.
   task automatic applyStimulus(input logic we, input logic be,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic ready);
      MemWrite         = we;
      BEDmem           = be;
      ALUResult        = addr;
      WriteData        = data;
      memIf.mem_wready = ready;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] drainData [4];
   logic [31:0] s36Addr [5];
   logic [31:0] s36Data [5];

   initial begin
      int          w;
      int          lane;
      int          op;
      logic        rdy;
      logic        isByte;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] expv;

      nChecks = 0;
      nFails  = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      rst_n = 1'b0;

      // Reset state.
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
      checkOutput("rst_wvalid", {31'b0, memIf.mem_wvalid}, 32'h0);
      checkOutput("rst_stall", {31'b0, StallM}, 32'h0);
      checkOutput("rst_raddr", {2'b0, memIf.mem_raddr}, 32'h41);
      tick();
      rst_n = 1'b1;

      // Word store, then read it back through forwarding.
      applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
      checkOutput("st_nostall", {31'b0, StallM}, 32'h0);
      checkOutput("st_nosameforward", ReadData, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
      checkOutput("w_wvalid", {31'b0, memIf.mem_wvalid}, 32'h1);
      checkOutput("w_waddr", {2'b0, memIf.mem_waddr}, 32'h40);
      checkOutput("w_wstrb", {28'b0, memIf.mem_wstrb}, 32'hF);
      checkOutput("w_wdata", memIf.mem_wdata, 32'hDEADBEEF);
      checkOutput("w_fwd", ReadData, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
      tick();
      checkOutput("w_drained", {31'b0, memIf.mem_wvalid}, 32'h0);
      checkOutput("w_ram", ram[8'h40], 32'hDEADBEEF);

      // Byte store merged over RAM data.
      ram[8'h40] = 32'h11223344;
      applyStimulus(1'b1, 1'b1, 32'h102, 32'h123456AA, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
      checkOutput("b_wordload", ReadData, 32'h11AA3344);
      checkOutput("b_wstrb", {28'b0, memIf.mem_wstrb}, 32'h4);
      checkOutput("b_wdata", memIf.mem_wdata, 32'hAAAAAAAA);
      applyStimulus(1'b0, 1'b1, 32'h102, 32'h0, 1'b0);
      checkOutput("b_byteload_hit", ReadData, 32'hAA);
      applyStimulus(1'b0, 1'b1, 32'h101, 32'h0, 1'b0);
      checkOutput("b_byteload_miss", ReadData, 32'h33);
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
      tick();
      checkOutput("b_ram", ram[8'h40], 32'h11AA3344);

      // Two stores to one word: youngest forwards, drain keeps order.
      applyStimulus(1'b1, 1'b0, 32'h200, 32'h1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h200, 32'h2, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 1'b0);
      checkOutput("y_fwd", ReadData, 32'h2);
      applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 1'b1);
      checkOutput("y_drain1", memIf.mem_wdata, 32'h1);
      tick();
      checkOutput("y_drain2_valid", {31'b0, memIf.mem_wvalid}, 32'h1);
      checkOutput("y_drain2", memIf.mem_wdata, 32'h2);
      tick();
      checkOutput("y_empty", {31'b0, memIf.mem_wvalid}, 32'h0);
      checkOutput("y_ram", ram[8'h80], 32'h2);

      // Fill to DEPTH, stall the fifth store, then push and pop together.
      s36Addr = '{32'h103, 32'h304, 32'h308, 32'h30C, 32'h310};
      s36Data = '{32'hCAFEF00D, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, s36Addr[i], s36Data[i], 1'b0);
         checkOutput($sformatf("f_nostall%0d", i), {31'b0, StallM}, 32'h0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, s36Addr[4], s36Data[4], 1'b0);
      checkOutput("f_stall", {31'b0, StallM}, 32'h1);
      checkOutput("f_misaligned_waddr", {2'b0, memIf.mem_waddr}, 32'h40);
      tick();
      applyStimulus(1'b1, 1'b0, s36Addr[4], s36Data[4], 1'b1);
      checkOutput("f_ready_nostall", {31'b0, StallM}, 32'h0);
      checkOutput("f_oldest", memIf.mem_wdata, 32'hCAFEF00D);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h314, 32'h66666666, 1'b0);
      checkOutput("f_stillfull", {31'b0, StallM}, 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h310, 32'h0, 1'b0);
      checkOutput("f_fwd_wrap", ReadData, 32'h55555555);
      drainData = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
      applyStimulus(1'b0, 1'b0, 32'h310, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("f_drainvalid%0d", i), {31'b0, memIf.mem_wvalid}, 32'h1);
         checkOutput($sformatf("f_draindata%0d", i), memIf.mem_wdata, drainData[i]);
         tick();
      end
      checkOutput("f_empty", {31'b0, memIf.mem_wvalid}, 32'h0);
      checkOutput("f_ram_last", ram[8'hC4], 32'h55555555);
      checkOutput("f_ram_first", ram[8'h40], 32'hCAFEF00D);

      // Reset in the middle of a cycle with three stores pending.
      ram[8] = 32'h0BADF00D;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h20 + 32'(4 * i), 32'h77777777, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
      checkOutput("r_pending", {31'b0, memIf.mem_wvalid}, 32'h1);
      checkOutput("r_fwd", ReadData, 32'h77777777);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("r_async_wvalid", {31'b0, memIf.mem_wvalid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      checkOutput("r_stall", {31'b0, StallM}, 32'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 1'b1);
      checkOutput("r_load", ReadData, 32'h0BADF00D);
      checkOutput("r_wvalid", {31'b0, memIf.mem_wvalid}, 32'h0);
      tick();
      checkOutput("r_ram", ram[8], 32'h0BADF00D);

      // Mixed stores, loads and ready toggling against a reference memory.
      for (int i = 0; i < 4; i++) begin
         ram[i]    = 32'h01010101 * (i + 1);
         refMem[i] = 32'h01010101 * (i + 1);
      end
      for (int n = 0; n < 80; n++) begin
         w      = $urandom_range(0, 3);
         lane   = $urandom_range(0, 3);
         op     = $urandom_range(0, 2);
         rdy    = 1'($urandom_range(0, 1));
         isByte = 1'($urandom_range(0, 1));
         addr   = 32'(w * 4 + lane);
         data   = $urandom;
         if (op == 2) begin
            applyStimulus(1'b0, isByte, addr, 32'h0, rdy);
            if (isByte) begin
               expv = {24'b0, refMem[w][8*lane +: 8]};
            end else begin
               expv = refMem[w];
            end
            checkOutput($sformatf("m_load%0d", n), ReadData, expv);
         end else begin
            applyStimulus(1'b1, (op == 1), addr, data, rdy);
            if (!StallM) begin
               if (op == 1) begin
                  refMem[w][8*lane +: 8] = data[7:0];
               end else begin
                  refMem[w] = data;
               end
            end
         end
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         if (memIf.mem_wvalid) tick();
      end
      checkOutput("m_drained", {31'b0, memIf.mem_wvalid}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("m_ram%0d", i), ram[i], refMem[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
